lsu_mem_stage: RTL and testbench

- Load/store unit in the memory stage, directly downstream of the ALU.
- Takes the ALU result as the effective address, plus store data and funct3.
- Issues one word-aligned request with byte enables to data memory over a gnt/rvalid handshake.
- Returns aligned, sign/zero-extended load data; stalls the pipeline until the access completes.

---
 rtl/lsu_mem_stage.sv | 215 +++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: turns the ALU effective address into one word-aligned
// data-memory request over a gnt/rvalid handshake and returns extended load data.
module lsu_mem_stage #(
    parameter int D_WIDTH = 32  // lane slicing below assumes a 32-bit word
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Valid,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [2:0]         Funct3,
    input  logic [D_WIDTH-1:0] ALUResult,
    input  logic [D_WIDTH-1:0] WriteData,
    output logic               Stall,
    output logic               ResultValid,
    output logic [D_WIDTH-1:0] LoadData,
    output logic               Fault,
    output logic               mem_req,
    output logic               mem_we,
    output logic [D_WIDTH-1:0] mem_addr,
    output logic [3:0]         mem_be,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [D_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t state;
    state_t state_next;

    // Access captured at acceptance; held for the whole transaction.
    logic [D_WIDTH-1:0] addr_q;
    logic [2:0]         funct3_q;
    logic               is_store_q;
    logic [3:0]         be_q;
    logic [D_WIDTH-1:0] wdata_q;
    logic               fault_q;
    logic [D_WIDTH-1:0] load_data_q;

    logic               access;
    logic               accept;
    logic               funct3_ok;
    logic               aligned;
    logic               illegal;
    logic [3:0]         be_new;
    logic [D_WIDTH-1:0] wdata_new;
    logic [7:0]         byte_lane;
    logic [15:0]        half_lane;
    logic [D_WIDTH-1:0] load_ext;

    assign access = Valid & (MemRead | MemWrite);
    assign accept = (state == IDLE) & access;

    // Legality of the incoming access: encoding, direction and natural alignment.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first,
        // so no path through the case leaves it unassigned and infers a latch.
        funct3_ok = 1'b0;
        aligned   = 1'b1;
        case (Funct3)
            F3_B: begin
                funct3_ok = 1'b1;
            end
            F3_H: begin
                funct3_ok = 1'b1;
                aligned   = ~ALUResult[0];
            end
            F3_W: begin
                funct3_ok = 1'b1;
                aligned   = (ALUResult[1:0] == 2'b00);
            end
            F3_BU: begin
                funct3_ok = ~MemWrite;
            end
            F3_HU: begin
                funct3_ok = ~MemWrite;
                aligned   = ~ALUResult[0];
            end
            default: begin
                funct3_ok = 1'b0;
            end
        endcase
        illegal = (MemRead & MemWrite) | ~funct3_ok | ~aligned;
    end

    // Byte enables and lane-replicated store data for the incoming access.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = WriteData;
        case (Funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << ALUResult[1:0];
                wdata_new = {4{WriteData[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {ALUResult[1], 1'b0};
                wdata_new = {2{WriteData[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = WriteData;
            end
        endcase
    end

    // Lane selection and extension of the returned read word.
    always_comb begin
        byte_lane = mem_rdata[7:0];
        case (addr_q[1:0])
            2'b00:   byte_lane = mem_rdata[7:0];
            2'b01:   byte_lane = mem_rdata[15:8];
            2'b10:   byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_ext = mem_rdata;
        case (funct3_q)
            F3_B:    load_ext = {{(D_WIDTH-8){byte_lane[7]}}, byte_lane};
            F3_BU:   load_ext = {{(D_WIDTH-8){1'b0}}, byte_lane};
            F3_H:    load_ext = {{(D_WIDTH-16){half_lane[15]}}, half_lane};
            F3_HU:   load_ext = {{(D_WIDTH-16){1'b0}}, half_lane};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (access) begin
                    state_next = illegal ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_next = is_store_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset too, because every bus output
        // is driven straight from them and must read 0 during reset.
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            funct3_q    <= '0;
            is_store_q  <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            fault_q     <= 1'b0;
            load_data_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state <= state_next;
            if (accept) begin
                if (illegal) begin
                    fault_q <= 1'b1;
                end else begin
                    addr_q     <= ALUResult;
                    funct3_q   <= Funct3;
                    is_store_q <= MemWrite;
                    be_q       <= be_new;
                    wdata_q    <= wdata_new;
                end
            end
            if (state == DONE) begin
                fault_q <= 1'b0;
            end
            if ((state == WAIT) && mem_rvalid) begin
                load_data_q <= load_ext;
            end
        end
    end

    // Stall drops in DONE so the pipeline advances on the completion cycle.
    assign Stall       = accept | (state == REQ) | (state == WAIT);
    assign ResultValid = (state == DONE);
    assign Fault       = fault_q;
    assign LoadData    = load_data_q;

    assign mem_req   = (state == REQ);
    assign mem_we    = (state == REQ) & is_store_q;
    assign mem_addr  = {addr_q[D_WIDTH-1:2], 2'b00};
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed scenarios plus randomized accesses
// compared against an arithmetic reference model of the load/store rules.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Valid;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        Stall;
    logic        ResultValid;
    logic [31:0] LoadData;
    logic        Fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_load;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] load;
        logic [3:0]  be;
        logic        we;
        logic        fault;
        logic        timeout;
        logic        hold_ok;
        int          stall_n;
        int          rv_cyc;
        int          req_n;
    } obs_t;

    typedef struct packed {
        logic        fault;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] load;
    } exp_t;

    lsu_mem_stage #(.D_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .Valid(Valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData), .Stall(Stall),
        .ResultValid(ResultValid), .LoadData(LoadData), .Fault(Fault), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: access size in bytes, offset in word, arithmetic extension.
    function automatic exp_t model(input bit rd, input bit wr, input bit [2:0] f3,
                                   input bit [31:0] addr, input bit [31:0] wdata,
                                   input bit [31:0] rdata);
        exp_t   e;
        int     size;
        int     ofs;
        longint v;
        size    = 1 << f3[1:0];
        ofs     = int'(addr % 4);
        e.fault = (rd && wr) || (f3 == 3'd3) || (f3 >= 3'd6) || (wr && f3[2]) || (addr % size != 0);
        e.addr  = addr - 32'(ofs);
        e.be    = 4'(((1 << size) - 1) << ofs);
        e.wdata = '0;
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
        e.load  = rdata;
        if (size <= 4) begin
            v = longint'(rdata >> (8 * ofs)) & ((longint'(1) << (8 * size)) - 1);
            if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
            e.load = 32'(v);
        end
        return e;
    endfunction

    // Drives one access from its IDLE cycle and plays the memory side; returns observations.
    // Entry and exit are at negedge+1 with the DUT in IDLE.
    task automatic do_access(input bit rd, input bit wr, input bit [2:0] f3, input bit [31:0] addr,
                             input bit [31:0] wdata, input bit [31:0] rdata, input int gnt_delay,
                             input int rv_delay, input bit noise, output obs_t o);
        int gnt_cyc;
        o = '0;
        o.rv_cyc  = -1;
        o.hold_ok = 1'b1;
        o.timeout = 1'b1;
        gnt_cyc   = -1;
        Valid = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; WriteData = wdata;
        #1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (Stall === 1'b1) o.stall_n++;
            if (mem_req === 1'b1) begin
                if (o.req_n == 0) begin
                    o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata; o.we = mem_we;
                end else if ({mem_addr, mem_be, mem_wdata, mem_we} !== {o.addr, o.be, o.wdata, o.we}) begin
                    o.hold_ok = 1'b0;
                end
                if (o.req_n == gnt_delay) begin
                    mem_gnt = 1'b1; gnt_cyc = cyc;
                end else if (noise) begin
                    mem_rvalid = 1'($urandom_range(0, 1));
                end
                o.req_n++;
            end
            if (rd && !wr && gnt_cyc >= 0 && cyc == gnt_cyc + 1 + rv_delay) begin
                mem_rvalid = 1'b1; mem_rdata = rdata;
            end
            if (ResultValid === 1'b1) begin
                o.rv_cyc = cyc; o.fault = Fault; o.load = LoadData; o.timeout = 1'b0;
                Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
            end
            @(negedge clk); #1;
            if (!o.timeout) break;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        if (o.timeout) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1; #1;
            last_load = '0;
        end
    endtask

    // Cycles with no access requested: Valid low, or Valid high with neither direction.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            Valid = 1'($urandom_range(0, 1));
            MemRead = Valid ? 1'b0 : 1'($urandom_range(0, 1));
            MemWrite = Valid ? 1'b0 : 1'($urandom_range(0, 1));
            Funct3 = 3'($urandom_range(0, 7)); ALUResult = $urandom; WriteData = $urandom;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            #1;
            checks++;
            if ({Stall, ResultValid, mem_req} !== 3'b000) begin
                errors++;
                $display("FAIL idle_quiet got stall/rv/req=%b want 000", {Stall, ResultValid, mem_req});
            end
            @(negedge clk); #1;
        end
        Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = '0; ALUResult = '0; WriteData = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        last_load = '0;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({mem_req, mem_we, ResultValid, Fault, Stall} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {mem_req, mem_we, ResultValid, Fault, Stall});
        end
        checks++;
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
        checks++;
        if (mem_be !== 4'h0) begin errors++; $display("FAIL reset_be got %b want 0000", mem_be); end
        checks++;
        if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
        checks++;
        if (LoadData !== 32'h0) begin errors++; $display("FAIL reset_load got %h want 0", LoadData); end
        @(negedge clk);
        rst_n = 1'b1; #1;
    endtask

    task automatic test_store_byte();
        obs_t o;
        do_access(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0, 1'b0, o);
        checks++;
        if (o.timeout !== 1'b0) begin errors++; $display("FAIL sb_timeout no ResultValid"); end
        checks++;
        if (o.addr !== 32'h1000) begin errors++; $display("FAIL sb_addr got %h want 00001000", o.addr); end
        checks++;
        if (o.be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b want 1000", o.be); end
        checks++;
        if (o.wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata got %h want abababab", o.wdata); end
        checks++;
        if (o.we !== 1'b1) begin errors++; $display("FAIL sb_we got %b want 1", o.we); end
        checks++;
        if (o.rv_cyc != 2 || o.stall_n != 2) begin
            errors++; $display("FAIL sb_latency got rv=%0d stall=%0d want rv=2 stall=2", o.rv_cyc, o.stall_n);
        end
        checks++;
        if (o.fault !== 1'b0 || o.load !== last_load) begin
            errors++; $display("FAIL sb_result got fault=%b load=%h want 0 %h", o.fault, o.load, last_load);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3_t   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] rd_t   [4] = '{32'h1280_FF34, 32'h1280_FF34, 32'h8001_7FFF, 32'h8001_7FFF};
        logic [31:0] want_t [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
        logic [3:0]  be_t   [4] = '{4'b0100, 4'b0100, 4'b1100, 4'b1100};
        obs_t o;
        for (int i = 0; i < 4; i++) begin
            do_access(1'b1, 1'b0, f3_t[i], 32'h0000_2002, 32'h5555_5555, rd_t[i], 0, 0, 1'b0, o);
            last_load = want_t[i];
            checks++;
            if (o.load !== want_t[i]) begin
                errors++; $display("FAIL load_ext[%0d] got %h want %h", i, o.load, want_t[i]);
            end
            checks++;
            if (o.rv_cyc != 3 || o.fault !== 1'b0) begin
                errors++; $display("FAIL load_lat[%0d] got rv=%0d fault=%b want rv=3 fault=0", i, o.rv_cyc, o.fault);
            end
            checks++;
            if ({o.addr, o.be, o.we} !== {32'h2000, be_t[i], 1'b0}) begin
                errors++; $display("FAIL load_bus[%0d] got %h/%b/%b want 00002000/%b/0", i, o.addr, o.be, o.we, be_t[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'h0, 0, 0, 1'b0, o);
        checks++;
        if (o.req_n != 0) begin errors++; $display("FAIL mis_req got %0d req cycles want 0", o.req_n); end
        checks++;
        if (o.fault !== 1'b1 || o.rv_cyc != 1 || o.stall_n != 1) begin
            errors++; $display("FAIL mis_fault got fault=%b rv=%0d stall=%0d want 1 1 1", o.fault, o.rv_cyc, o.stall_n);
        end
        checks++;
        if (o.load !== last_load) begin errors++; $display("FAIL mis_load got %h want %h", o.load, last_load); end
        checks++;
        if ({Fault, ResultValid} !== 2'b00) begin
            errors++; $display("FAIL mis_clear got fault/rv=%b want 00", {Fault, ResultValid});
        end
    endtask

    task automatic test_wait_states();
        obs_t o;
        do_access(1'b0, 1'b1, 3'b010, 32'h0000_5004, 32'hCAFE_F00D, 32'h0, 3, 0, 1'b0, o);
        checks++;
        if (o.req_n != 4 || o.hold_ok !== 1'b1) begin
            errors++; $display("FAIL sw_hold got req=%0d hold=%b want 4 1", o.req_n, o.hold_ok);
        end
        checks++;
        if ({o.addr, o.be, o.wdata, o.we} !== {32'h5004, 4'hF, 32'hCAFE_F00D, 1'b1}) begin
            errors++; $display("FAIL sw_bus got %h/%b/%h/%b want 00005004/1111/cafef00d/1", o.addr, o.be, o.wdata, o.we);
        end
        checks++;
        if (o.rv_cyc != 5 || o.stall_n != 5) begin
            errors++; $display("FAIL sw_latency got rv=%0d stall=%0d want 5 5", o.rv_cyc, o.stall_n);
        end
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_6008, 32'h0, 32'h89AB_CDEF, 0, 4, 1'b0, o);
        last_load = 32'h89AB_CDEF;
        checks++;
        if (o.rv_cyc != 7 || o.stall_n != 7) begin
            errors++; $display("FAIL lw_wait got rv=%0d stall=%0d want 7 7", o.rv_cyc, o.stall_n);
        end
        checks++;
        if (o.load !== 32'h89AB_CDEF) begin errors++; $display("FAIL lw_data got %h want 89abcdef", o.load); end
    endtask

    task automatic test_back_to_back();
        logic        rd_t [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3_t [5] = '{3'b010, 3'b010, 3'b100, 3'b001, 3'b000};
        logic [31:0] ad_t [5] = '{32'h7000, 32'h7000, 32'h7001, 32'h7001, 32'h7002};
        obs_t o;
        exp_t e;
        int   lat;
        for (int i = 0; i < 5; i++) begin
            e = model(rd_t[i], !rd_t[i], f3_t[i], ad_t[i], 32'h1122_3344, 32'hA1B2_C3D4);
            do_access(rd_t[i], !rd_t[i], f3_t[i], ad_t[i], 32'h1122_3344, 32'hA1B2_C3D4, 0, 0, 1'b0, o);
            if (rd_t[i] && !e.fault) last_load = e.load;
            lat = e.fault ? 1 : (rd_t[i] ? 3 : 2);
            checks++;
            if (o.rv_cyc != lat || o.stall_n != lat || o.fault !== e.fault || o.load !== last_load) begin
                errors++;
                $display("FAIL b2b[%0d] got rv=%0d stall=%0d fault=%b load=%h want %0d %0d %b %h",
                         i, o.rv_cyc, o.stall_n, o.fault, o.load, lat, lat, e.fault, last_load);
            end
        end
    endtask

    task automatic test_reset_mid();
        Valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b010; ALUResult = 32'h4000; WriteData = 32'h0BAD_F00D;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_before got %b want 1", mem_req); end
        #2;
        rst_n = 1'b0; Valid = 1'b0; MemWrite = 1'b0;
        #1;
        checks++;
        if ({mem_req, Stall, ResultValid} !== 3'b000) begin
            errors++; $display("FAIL rstmid_drop got req/stall/rv=%b want 000", {mem_req, Stall, ResultValid});
        end
        @(negedge clk);
        rst_n = 1'b1; #1;
        last_load = '0;
        for (int i = 0; i < 4; i++) begin
            mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
            checks++;
            if ({ResultValid, Stall, mem_req} !== 3'b000) begin
                errors++; $display("FAIL rstmid_ignore[%0d] got rv/stall/req=%b want 000", i, {ResultValid, Stall, mem_req});
            end
            @(negedge clk); #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        checks++;
        if (LoadData !== 32'h0) begin errors++; $display("FAIL rstmid_load got %h want 0", LoadData); end
    endtask

    task automatic test_random();
        bit [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int n = 0; n < 150; n++) begin
            bit       rd;
            bit       wr;
            bit [2:0] f3;
            bit [31:0] addr;
            bit [31:0] wd;
            bit [31:0] rdat;
            int       kind;
            int       gd;
            int       rvd;
            int       lat;
            exp_t     e;
            obs_t     o;
            kind = int'($urandom_range(0, 19));
            rd   = (kind < 9) || (kind == 19);
            wr   = (kind >= 9);
            if ($urandom_range(0, 3) != 0) f3 = wr ? legal_f3[$urandom_range(0, 2)] : legal_f3[$urandom_range(0, 4)];
            else f3 = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            wd   = $urandom;
            rdat = $urandom;
            gd   = int'($urandom_range(0, 3));
            rvd  = int'($urandom_range(0, 3));
            e    = model(rd, wr, f3, addr, wd, rdat);
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
            do_access(rd, wr, f3, addr, wd, rdat, gd, rvd, 1'b1, o);
            if (rd && !wr && !e.fault) last_load = e.load;
            lat = e.fault ? 1 : (wr ? gd + 2 : gd + rvd + 3);
            checks++;
            if (o.timeout !== 1'b0 || o.rv_cyc != lat || o.stall_n != lat || o.fault !== e.fault) begin
                errors++;
                $display("FAIL rnd[%0d] ctrl f3=%0d rd=%b wr=%b a=%h got to=%b rv=%0d stall=%0d fault=%b want rv=%0d fault=%b",
                         n, f3, rd, wr, addr, o.timeout, o.rv_cyc, o.stall_n, o.fault, lat, e.fault);
            end
            checks++;
            if (o.load !== last_load) begin
                errors++; $display("FAIL rnd[%0d] load got %h want %h", n, o.load, last_load);
            end
            checks++;
            if (e.fault) begin
                if (o.req_n != 0) begin errors++; $display("FAIL rnd[%0d] fault_req got %0d want 0", n, o.req_n); end
            end else if ({o.addr, o.be, o.wdata, o.we} !== {e.addr, e.be, e.wdata, wr} ||
                         o.req_n != gd + 1 || o.hold_ok !== 1'b1) begin
                errors++;
                $display("FAIL rnd[%0d] bus got %h/%b/%h/%b req=%0d hold=%b want %h/%b/%h/%b req=%0d",
                         n, o.addr, o.be, o.wdata, o.we, o.req_n, o.hold_ok, e.addr, e.be, e.wdata, wr, gd + 1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_byte();
        test_load_ext();
        test_misaligned();
        test_wait_states();
        test_back_to_back();
        test_reset_mid();
        idle_cycles(3);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
